// File: rtl/led_matrix_scan_if.sv
// ============================================================================
// Module      : led_matrix_scan_if
// Description : Frame-load valid/ready channel for the LED matrix scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface led_matrix_scan_if;
  logic [31:0] fb_data;
  logic        fb_valid;
  logic        fb_ready;

  modport master (output fb_data, output fb_valid, input fb_ready);
  modport slave  (input fb_data, input fb_valid, output fb_ready);
endinterface

`default_nettype wire

// File: rtl/led_matrix_scan.sv
// ============================================================================
// Module      : led_matrix_scan
// Description : 8x4 active-low LED matrix scanner with blanking and
//               tear-free double-buffered frame loading.
//               Optional macro LED_SCAN_PWM_EN adds 4-bit brightness PWM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module led_matrix_scan #(
  parameter int COL_TICKS   = 12000,
  parameter int BLANK_TICKS = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  led_matrix_scan_if.slave  fb,
`ifdef LED_SCAN_PWM_EN
  input  logic [3:0]        bright,
`endif
  output logic [7:0]        led,
  output logic [3:0]        lcol,
  output logic              frame_start
);

  localparam int c_max_ticks = (COL_TICKS > BLANK_TICKS) ? COL_TICKS : BLANK_TICKS;
  localparam int c_tw        = (c_max_ticks > 1) ? $clog2(c_max_ticks) : 1;
  localparam logic [c_tw-1:0] c_col_last   = c_tw'(COL_TICKS - 1);
  localparam logic [c_tw-1:0] c_blank_last = c_tw'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t          r_state, w_state_n;
  logic [c_tw-1:0] r_tick, w_tick_n;
  logic [1:0]      r_col, w_col_n;
  logic [31:0]     r_active, r_pend, w_active_n;
  logic            r_pend_full;
  logic            w_boundary, w_swap, w_xfer;
  logic [7:0]      w_led_n;
  logic [3:0]      w_lcol_n;
  logic            w_fs_n;
`ifdef LED_SCAN_PWM_EN
  logic [3:0]      r_phase, w_phase_n;
  logic [3:0]      r_bright_q, w_bright_n;
`endif

  assign fb.fb_ready = !r_pend_full;
  assign w_xfer      = fb.fb_valid && !r_pend_full;

  always_comb begin
    w_state_n  = r_state;
    w_tick_n   = r_tick + 1'b1;
    w_col_n    = r_col;
    w_boundary = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (BLANK_TICKS == 0 || r_tick == c_blank_last) begin
          w_state_n = ST_DRIVE;
          w_tick_n  = '0;
        end
      end
      ST_DRIVE: begin
        if (r_tick == c_col_last) begin
          w_tick_n   = '0;
          w_col_n    = r_col + 2'd1;
          w_boundary = (r_col == 2'd3);
          w_state_n  = (BLANK_TICKS == 0) ? ST_DRIVE : ST_BLANK;
        end
      end
      default: begin
        w_state_n = ST_BLANK;
        w_tick_n  = '0;
      end
    endcase

    // The swap is folded into the output path so column 0 of the new frame
    // already shows the new image even when there is no blanking gap.
    w_swap     = w_boundary && r_pend_full;
    w_active_n = w_swap ? r_pend : r_active;

    w_led_n  = 8'hFF;
    w_lcol_n = 4'hF;
    w_fs_n   = 1'b0;
    if (w_state_n == ST_DRIVE) begin
      w_lcol_n = ~(4'b0001 << w_col_n);
      w_led_n  = ~w_active_n[8*w_col_n +: 8];
      w_fs_n   = (w_col_n == 2'd0) && (w_tick_n == '0);
    end

`ifdef LED_SCAN_PWM_EN
    w_bright_n = w_boundary ? bright : r_bright_q;
    w_phase_n  = (w_state_n == ST_DRIVE && w_tick_n != '0) ? r_phase + 4'd1 : 4'd0;
    if (w_phase_n >= w_bright_n) begin
      w_led_n = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BLANK;
      r_tick      <= '0;
      r_col       <= 2'd0;
      r_active    <= 32'd0;
      r_pend      <= 32'd0;
      r_pend_full <= 1'b0;
      led         <= 8'hFF;
      lcol        <= 4'hF;
      frame_start <= 1'b0;
`ifdef LED_SCAN_PWM_EN
      r_phase     <= 4'd0;
      r_bright_q  <= 4'hF;
`endif
    end else begin
      r_state     <= w_state_n;
      r_tick      <= w_tick_n;
      r_col       <= w_col_n;
      r_active    <= w_active_n;
      led         <= w_led_n;
      lcol        <= w_lcol_n;
      frame_start <= w_fs_n;
`ifdef LED_SCAN_PWM_EN
      r_phase     <= w_phase_n;
      r_bright_q  <= w_bright_n;
`endif
      // ready is low whenever a swap is possible, so the two never coincide
      if (w_swap) begin
        r_pend_full <= 1'b0;
      end else if (w_xfer) begin
        r_pend      <= fb.fb_data;
        r_pend_full <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
// ============================================================================
// Module      : tb_led_matrix_scan
// Description : Self-checking bench for led_matrix_scan (blanked and
//               blank-free instances) against a frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_led_matrix_scan;

  localparam int B = 2;
`ifdef LED_SCAN_PWM_EN
  localparam int C = 32;
`else
  localparam int C = 16;
`endif
  localparam int P  = 4 * (B + C);
  localparam int PB = 4 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bright = 4'hF;
  logic [7:0] led_a, led_b;
  logic [3:0] lcol_a, lcol_b;
  logic       fs_a, fs_b;

  led_matrix_scan_if ifa();
  led_matrix_scan_if ifb();

  always #5 clk = ~clk;

  led_matrix_scan #(.COL_TICKS(C), .BLANK_TICKS(B)) dut_a (
    .clk(clk), .rst_n(rst_n), .fb(ifa),
`ifdef LED_SCAN_PWM_EN
    .bright(bright),
`endif
    .led(led_a), .lcol(lcol_a), .frame_start(fs_a)
  );

  led_matrix_scan #(.COL_TICKS(C), .BLANK_TICKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .fb(ifb),
`ifdef LED_SCAN_PWM_EN
    .bright(bright),
`endif
    .led(led_b), .lcol(lcol_b), .frame_start(fs_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the frame is derived from the edge count
  int          t_a, t_b, m_p;
  bit          m_full;
  logic [31:0] m_pend, m_active;
  logic [3:0]  m_bq;
  logic [7:0]  exp_led;
  logic [3:0]  exp_lcol, exp_lcol_b;
  bit          exp_fs, exp_fs_b, exp_ready;

  task automatic model_reset();
    t_a = 0; t_b = 0; m_p = 0;
    m_full = 0; m_pend = '0; m_active = '0; m_bq = 4'hF;
    exp_led = 8'hFF; exp_lcol = 4'hF; exp_fs = 0; exp_ready = 1;
    exp_lcol_b = 4'hF; exp_fs_b = 0;
  endtask

  task automatic step();
    bit xfer;
    logic [31:0] din;
    logic [3:0] br;
    logic [7:0] pat;
    int col, q, d, pb;
    xfer = ifa.fb_valid && !m_full;
    din  = ifa.fb_data;
    br   = bright;
    @(posedge clk);
    t_a++; t_b++;
    m_p = t_a % P;
    if (m_p == 0) begin
      if (m_full) begin
        m_active = m_pend;
        m_full   = 0;
      end
      m_bq = br;
    end
    if (xfer) begin
      m_pend = din;
      m_full = 1;
    end
    exp_ready = !m_full;
    col = m_p / (B + C);
    q   = m_p % (B + C);
    if (q < B) begin
      exp_led = 8'hFF; exp_lcol = 4'hF; exp_fs = 0;
    end else begin
      d   = q - B;
      pat = ~m_active[8*col +: 8];
`ifdef LED_SCAN_PWM_EN
      if ((d % 16) >= int'(m_bq)) pat = 8'hFF;
`endif
      exp_led  = pat;
      exp_lcol = ~(4'b0001 << col);
      exp_fs   = (m_p == B);
    end
    pb = (t_b - 1) % PB;
    exp_lcol_b = ~(4'b0001 << (pb / C));
    exp_fs_b   = (pb == 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    ifa.fb_valid = 0; ifa.fb_data = '0;
    ifb.fb_valid = 0; ifb.fb_data = '0;
    rst_n = 0;
    model_reset();
    repeat (5) @(negedge clk);
    vectors++;
    if (led_a !== 8'hFF || lcol_a !== 4'hF || fs_a !== 1'b0 || ifa.fb_ready !== 1'b1 ||
        led_b !== 8'hFF || lcol_b !== 4'hF || fs_b !== 1'b0 || ifb.fb_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values led=%h lcol=%h fs=%b rdy=%b / b: led=%h lcol=%h fs=%b rdy=%b (want FF F 0 1)",
               led_a, lcol_a, fs_a, ifa.fb_ready, led_b, lcol_b, fs_b, ifb.fb_ready);
    end
    rst_n = 1;
    n = 0;
    while (fs_a !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    vectors++;
    if (n != B) begin
      miscompares++;
      $display("FAIL first_frame_start got %0d cycles, want %0d", n, B);
    end
  endtask

  task automatic test_frame_load();
    logic [7:0] tab [4];
    logic [3:0] prev;
    logic [7:0] want;
    int last_fs;
    tab[0] = 8'hFE; tab[1] = 8'hDF; tab[2] = 8'hBF; tab[3] = 8'h7F;
    ifa.fb_valid = 1; ifa.fb_data = 32'h8040_2001;
    step();
    ifa.fb_valid = 0;
    vectors++;
    if (ifa.fb_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_ready_low rdy=%b want 0", ifa.fb_ready);
    end
    prev = exp_lcol;
    last_fs = -1;
    for (int i = 0; i < 2 * P; i++) begin
      step();
      vectors++;
      if (led_a !== exp_led || lcol_a !== exp_lcol || fs_a !== exp_fs || ifa.fb_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL frame_load t=%0d led=%h/%h lcol=%h/%h fs=%b/%b rdy=%b/%b", t_a,
                 led_a, exp_led, lcol_a, exp_lcol, fs_a, exp_fs, ifa.fb_ready, exp_ready);
      end
      if (m_active == 32'h8040_2001 && prev == 4'hF && exp_lcol != 4'hF) begin
        want = 8'hFF;
        for (int c = 0; c < 4; c++) if (exp_lcol == ~(4'b0001 << c)) want = tab[c];
        vectors++;
        if (led_a !== want) begin
          miscompares++;
          $display("FAIL column_pattern lcol=%h led=%h want %h", lcol_a, led_a, want);
        end
      end
      if (fs_a === 1'b1) begin
        if (last_fs >= 0) begin
          vectors++;
          if (t_a - last_fs != P) begin
            miscompares++;
            $display("FAIL frame_period got %0d want %0d", t_a - last_fs, P);
          end
        end
        last_fs = t_a;
      end
      prev = exp_lcol;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    int n;
    a = $urandom; b = ~a;
    n = 0;
    while (m_p != B + C / 2 && n < 2 * P) begin step(); n++; end
    ifa.fb_valid = 1; ifa.fb_data = a;
    step();
    vectors++;
    if (ifa.fb_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ready_low rdy=%b want 0", ifa.fb_ready);
    end
    ifa.fb_data = b;
    n = 0;
    while (m_p != P - 1 && n < 2 * P) begin
      step();
      n++;
      vectors++;
      if (led_a !== exp_led || lcol_a !== exp_lcol || ifa.fb_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL bp_hold t=%0d led=%h/%h lcol=%h/%h rdy=%b/%b", t_a,
                 led_a, exp_led, lcol_a, exp_lcol, ifa.fb_ready, exp_ready);
      end
    end
    ifa.fb_valid = 0;
    step();
    vectors++;
    if (ifa.fb_ready !== 1'b1 || m_active !== a) begin
      miscompares++;
      $display("FAIL bp_swap rdy=%b want 1", ifa.fb_ready);
    end
    n = 0;
    while (fs_a !== 1'b1 && n < P) begin step(); n++; end
    vectors++;
    if (led_a !== ~a[7:0] || lcol_a !== 4'hE) begin
      miscompares++;
      $display("FAIL bp_new_frame led=%h want %h lcol=%h want E", led_a, ~a[7:0], lcol_a);
    end
    for (int i = 0; i < P; i++) begin
      step();
      vectors++;
      if (led_a !== exp_led || lcol_a !== exp_lcol || fs_a !== exp_fs) begin
        miscompares++;
        $display("FAIL bp_frame t=%0d led=%h/%h lcol=%h/%h fs=%b/%b", t_a,
                 led_a, exp_led, lcol_a, exp_lcol, fs_a, exp_fs);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 4 * P; i++) begin
      ifa.fb_valid = ($urandom_range(0, 5) == 0);
      ifa.fb_data  = $urandom;
      step();
      vectors++;
      if (led_a !== exp_led || lcol_a !== exp_lcol || fs_a !== exp_fs || ifa.fb_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL random t=%0d led=%h/%h lcol=%h/%h fs=%b/%b rdy=%b/%b", t_a,
                 led_a, exp_led, lcol_a, exp_lcol, fs_a, exp_fs, ifa.fb_ready, exp_ready);
      end
    end
    ifa.fb_valid = 0;
  endtask

  task automatic test_no_blank();
    for (int i = 0; i < 2 * PB; i++) begin
      step();
      vectors++;
      if (lcol_b !== exp_lcol_b || fs_b !== exp_fs_b || led_b !== 8'hFF ||
          $countones(~lcol_b) > 1 || $countones(~lcol_a) > 1) begin
        miscompares++;
        $display("FAIL no_blank t=%0d lcol=%h/%h fs=%b/%b led=%h/FF lcol_a=%h", t_b,
                 lcol_b, exp_lcol_b, fs_b, exp_fs_b, led_b, lcol_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] img;
    int n;
    img = $urandom | 32'h0081_0000;
    n = 0;
    while (ifa.fb_ready !== 1'b1 && n < 2 * P) begin step(); n++; end
    ifa.fb_valid = 1; ifa.fb_data = img;
    step();
    ifa.fb_valid = 0;
    n = 0;
    while (!(m_active == img && m_p == 2 * (B + C) + B + 3) && n < 3 * P) begin step(); n++; end
    vectors++;
    if (lcol_a !== 4'hB || led_a !== ~img[23:16]) begin
      miscompares++;
      $display("FAIL mid_col2 lcol=%h want B led=%h want %h", lcol_a, led_a, ~img[23:16]);
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if (led_a !== 8'hFF || lcol_a !== 4'hF || fs_a !== 1'b0 || ifa.fb_ready !== 1'b1 || lcol_b !== 4'hF) begin
      miscompares++;
      $display("FAIL async_reset led=%h lcol=%h fs=%b rdy=%b lcol_b=%h want FF F 0 1 F",
               led_a, lcol_a, fs_a, ifa.fb_ready, lcol_b);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < P; i++) begin
      step();
      vectors++;
      if (led_a !== exp_led || lcol_a !== exp_lcol || fs_a !== exp_fs || led_a !== 8'hFF) begin
        miscompares++;
        $display("FAIL after_reset t=%0d led=%h/%h lcol=%h/%h fs=%b/%b", t_a,
                 led_a, exp_led, lcol_a, exp_lcol, fs_a, exp_fs);
      end
    end
  endtask

`ifdef LED_SCAN_PWM_EN
  task automatic test_pwm();
    int n, dc;
    logic [3:0] prev;
    logic [7:0] want;
    bright = 4'd4;
    n = 0;
    while (ifa.fb_ready !== 1'b1 && n < 2 * P) begin step(); n++; end
    ifa.fb_valid = 1; ifa.fb_data = 32'hFFFF_FFFF;
    step();
    ifa.fb_valid = 0;
    n = 0;
    while (!(m_active == 32'hFFFF_FFFF && m_bq == 4'd4 && exp_fs) && n < 3 * P) begin step(); n++; end
    dc = 0;
    prev = exp_lcol;
    for (int i = 0; i < P; i++) begin
      vectors++;
      want = (dc % 16 < 4) ? 8'h00 : 8'hFF;
      if (exp_lcol == 4'hF) want = 8'hFF;
      if (led_a !== want || led_a !== exp_led || lcol_a !== exp_lcol) begin
        miscompares++;
        $display("FAIL pwm4 t=%0d phase=%0d led=%h want %h lcol=%h/%h", t_a, dc % 16,
                 led_a, want, lcol_a, exp_lcol);
      end
      step();
      if (exp_lcol != 4'hF && prev == 4'hF) dc = 0;
      else if (exp_lcol != 4'hF) dc++;
      prev = exp_lcol;
    end
    bright = 4'd0;
    for (int i = 0; i < 2 * P; i++) begin
      step();
      vectors++;
      if (led_a !== exp_led || lcol_a !== exp_lcol || (m_bq == 4'd0 && led_a !== 8'hFF)) begin
        miscompares++;
        $display("FAIL pwm0 t=%0d led=%h/%h lcol=%h/%h", t_a, led_a, exp_led, lcol_a, exp_lcol);
      end
    end
    bright = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_frame_load();
    test_backpressure();
    test_random_frames();
    test_no_blank();
    test_reset_mid();
`ifdef LED_SCAN_PWM_EN
    test_pwm();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
